// File: rtl/fir_pkg.sv
// Shared definitions for the transmit raised-cosine FIR slice: state encoding and defaults.
package fir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int DEF_NB_IN     = 8;
  localparam int DEF_OS_FACTOR = 4;
  localparam int DEF_FIR_LEN   = 24;

  // fir_rc registers its products before the adder tree, so its output lags i_en by this much.
  localparam int FIR_PROD_REG_DEPTH = 2;
  localparam int DEF_OUT_LAT        = FIR_PROD_REG_DEPTH;

endpackage

// File: rtl/fir_tick_gen.sv
// Sample-tick divider: counts 0..DIV-1 while enabled and flags the last count.
module fir_tick_gen #(
  parameter int DIV    = 1,
  parameter int NB_DIV = 4
) (
  input  logic clk,
  input  logic i_reset,
  input  logic i_en,
  input  logic i_clr,
  output logic o_tick
);

  localparam logic [NB_DIV-1:0] DIV_LAST = NB_DIV'(DIV - 1);

  logic [NB_DIV-1:0] r_divCnt;

  assign o_tick = i_en & (r_divCnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (!i_reset || i_clr)
      r_divCnt <= '0;
    else if (i_en)
      r_divCnt <= (r_divCnt == DIV_LAST) ? '0 : r_divCnt + NB_DIV'(1);
  end

endmodule

// File: rtl/fir_tx_sequencer.sv
// Transmit FIR sequencer: pulls symbols at symbol rate, zero-stuffs to the oversampled
// rate, flushes the FIR delay line on stop and flags when the FIR output is valid.
module fir_tx_sequencer
  import fir_pkg::*;
#(
  parameter int NB_IN     = DEF_NB_IN,
  parameter int OS_FACTOR = DEF_OS_FACTOR,
  parameter int NB_PHASE  = 2,
  parameter int DIV       = 1,
  parameter int NB_DIV    = 4,
  parameter int FIR_LEN   = DEF_FIR_LEN,
  parameter int NB_FLUSH  = 5,
  parameter int OUT_LAT   = DEF_OUT_LAT
) (
  input  logic                clk,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic                i_stop,
  input  logic [NB_IN-1:0]    i_sym,
  input  logic                i_sym_valid,
  output logic                o_sym_ready,
  output logic [NB_IN-1:0]    o_fir_data,
  output logic                o_fir_en,
  output logic                o_fir_valid,
  output logic                o_out_valid,
  output logic                o_underflow,
  output logic                o_busy,
  output logic [NB_PHASE-1:0] o_phase
);

  localparam logic [NB_PHASE-1:0] PHASE_LAST = NB_PHASE'(OS_FACTOR - 1);
  localparam logic [NB_FLUSH-1:0] FLUSH_LAST = NB_FLUSH'(FIR_LEN - 1);

  state_t              r_state;
  logic [NB_PHASE-1:0] r_phase;
  logic [NB_FLUSH-1:0] r_flushCnt;
  logic [OUT_LAT-1:0]  r_outPipe;
  logic                w_tick;
  logic                w_symPhase;
  logic                w_accept;

  fir_tick_gen #(
    .DIV    (DIV),
    .NB_DIV (NB_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .i_reset (i_reset),
    .i_en    (r_state != ST_IDLE),
    .i_clr   (r_state == ST_IDLE),
    .o_tick  (w_tick)
  );

  assign w_symPhase  = (r_phase == '0);
  assign o_sym_ready = (r_state == ST_RUN) & w_tick & w_symPhase;
  assign w_accept    = o_sym_ready & i_sym_valid;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_phase     = r_phase;
  assign o_out_valid = r_outPipe[OUT_LAT-1];

  // A tick in the cycle stop arrives is still a RUN tick, so a last symbol can slip in.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_flushCnt  <= '0;
      o_fir_en    <= 1'b0;
      o_fir_valid <= 1'b0;
      o_fir_data  <= '0;
      o_underflow <= 1'b0;
    end else begin
      o_fir_en    <= 1'b0;
      o_fir_valid <= 1'b0;
      o_fir_data  <= '0;
      o_underflow <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_start && !i_stop) begin
            r_state <= ST_RUN;
            r_phase <= '0;
          end
        end
        ST_RUN: begin
          if (w_tick) begin
            o_fir_en    <= 1'b1;
            o_fir_valid <= w_accept;
            o_fir_data  <= w_accept ? i_sym : '0;
            o_underflow <= w_symPhase & ~i_sym_valid;
            r_phase     <= (r_phase == PHASE_LAST) ? '0 : r_phase + NB_PHASE'(1);
          end
          if (i_stop) begin
            r_state    <= ST_FLUSH;
            r_flushCnt <= '0;
          end
        end
        ST_FLUSH: begin
          if (w_tick) begin
            o_fir_en <= 1'b1;
            if (r_flushCnt == FLUSH_LAST)
              r_state <= ST_IDLE;
            else
              r_flushCnt <= r_flushCnt + NB_FLUSH'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Tracks the FIR's product-register latency; keeps draining after the FSM goes idle.
  always_ff @(posedge clk) begin
    if (!i_reset) begin
      r_outPipe <= '0;
    end else begin
      r_outPipe[0] <= o_fir_en;
      for (int i = 1; i < OUT_LAT; i++)
        r_outPipe[i] <= r_outPipe[i-1];
    end
  end

endmodule

// File: doc/fir_tx_sequencer.md
Name: fir_tx_sequencer

Overview:
Sequencer for the transmit raised-cosine FIR (fir_rc). Pulls symbols from an upstream source at symbol rate and zero-stuffs them to the oversampled rate. Drives the FIR's i_en/i_valid/i_is_data and flushes the delay line on stop. Emits an output-valid strobe aligned to the FIR's registered-product latency.

Parameters:
NB_IN, 8, symbol/FIR input width (signed, S(8,7))
OS_FACTOR, 4, oversampling factor; samples per symbol (>=2)
NB_PHASE, 2, width of phase counter, >= clog2(OS_FACTOR)
DIV, 1, clocks per sample tick (>=1); 1 = a tick every clock
NB_DIV, 4, width of divider counter, >= clog2(DIV)+1
FIR_LEN, 24, FIR taps; flush length in sample ticks
NB_FLUSH, 5, width of flush counter, >= clog2(FIR_LEN+1)
OUT_LAT, 2, clocks from o_fir_en high to FIR output valid

Ports:
clk  input  1  clock
i_reset  input  1  synchronous, active-low reset
i_start  input  1  pulse: begin streaming
i_stop  input  1  pulse: stop streaming and flush
i_sym  input  NB_IN  signed symbol from source
i_sym_valid  input  1  source has a symbol available
o_sym_ready  output  1  symbol consumed this cycle when i_sym_valid is also high
o_fir_data  output  NB_IN  to FIR i_is_data
o_fir_en  output  1  to FIR i_en; one-clock pulse per sample tick
o_fir_valid  output  1  to FIR i_valid; high only on symbol phase with a symbol
o_out_valid  output  1  FIR o_sample is valid for the new sample this cycle
o_underflow  output  1  one-clock pulse: symbol phase with no symbol available
o_busy  output  1  state != IDLE
o_phase  output  NB_PHASE  current phase counter value

Behaviour:
- Reset: i_reset is synchronous, active-low; clock clk. When i_reset=0 at a clk edge: state=IDLE; all counters=0; o_fir_en=o_fir_valid=o_out_valid=o_underflow=0; o_fir_data=0; OUT_LAT pipeline cleared. A reset mid-RUN or mid-FLUSH aborts immediately with no flush.
- States: IDLE, RUN, FLUSH. The state encoding constant is shared.
- IDLE: no ticks, o_fir_en=0. i_start=1 and i_stop=0 -> RUN, with div_cnt=0 and phase=0. i_start and i_stop both high -> stay IDLE, because stop has priority.
- Tick: in RUN/FLUSH, div_cnt counts 0..DIV-1 and wraps. tick = (div_cnt==DIV-1). With DIV=1, tick is high every clock.
- RUN, tick cycle: phase increments mod OS_FACTOR, wrapping OS_FACTOR-1 -> 0.
  - If phase==0 on the tick, o_sym_ready=1 combinationally. o_sym_ready is 0 in every other cycle.
  - Accept = i_sym_valid & o_sym_ready.
- Next clock after every tick (registered outputs):
  - o_fir_en=1.
  - o_fir_valid = accept.
  - o_fir_data = accept ? i_sym : 0.
  - o_underflow = (phase==0 & ~i_sym_valid), RUN only.
- Non-symbol phases always give o_fir_valid=0 and o_fir_data=0 (zero-stuffing).
- RUN + i_stop -> FLUSH at the next edge. flush_cnt is cleared. A tick in that same cycle is still processed as RUN, so a symbol may be accepted. i_start in RUN or FLUSH is ignored.
- FLUSH: ticks continue. Each tick issues o_fir_en=1 next clock with o_fir_valid=0, o_fir_data=0, o_sym_ready=0. flush_cnt increments per tick. The tick that reaches flush_cnt==FIR_LEN-1 moves to IDLE, so exactly FIR_LEN zero samples are pushed. i_stop in FLUSH is ignored.
- o_out_valid: o_fir_en delayed by exactly OUT_LAT clocks through a shift register. It keeps draining after return to IDLE and is cleared only by reset.
- o_busy = (state != IDLE). o_phase reflects the phase register.
- No arithmetic on sample data; data passes through unchanged.

Decomposition:
- Shared package (fir_pkg): state encoding localparams (ST_IDLE=2'd0, ST_RUN=2'd1, ST_FLUSH=2'd2), default OS_FACTOR/FIR_LEN/NB_IN, OUT_LAT tied to the FIR's product-register depth.
- Sub-module fir_tick_gen: DIV counter with enable/clear, output tick. Everything else is flat.

Test Plan:
1. DIV=1, OS=4, i_sym_valid=1, i_sym=0x40, start -> o_sym_ready high every 4th clock. o_fir_en high every clock after the first; o_fir_valid pattern 1,0,0,0 with data 0x40,0,0,0. o_out_valid follows o_fir_en by 2 clocks.
2. DIV=3, OS=4, start -> o_fir_en is a 1-clock pulse every 3 clocks. o_sym_ready is only in every 12th clock.
3. i_sym_valid=0 on one symbol phase -> o_underflow pulses once, the corresponding o_fir_valid=0 with data 0, and the phase sequence is unchanged.
4. i_stop during RUN -> exactly 24 further o_fir_en pulses, all with o_fir_valid=0. Then IDLE and o_busy=0, with 2 trailing o_out_valid pulses.
5. i_start and i_stop together in IDLE -> stays IDLE. i_start during FLUSH -> ignored, flush still completes in 24 ticks.
6. i_reset=0 mid-RUN at phase 2 -> next clock: IDLE with all outputs 0. A later start begins at phase 0.
